instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch -- IF stage of the 32-bit word-indexed MIPS pipeline.
//
// Holds the program counter, presents it to the combinational instruction
// memory and registers the returned word into IF/ID. Stall, flush and the
// decode-resolved redirects (JumpReg > Jump > BranchTaken) steer the PC.
//
// Optional feature, enabled by defining FETCH_BOUNDS_CHECK_EN:
//   a sequential fetch from PC >= IMEM_DEPTH sets the sticky FetchFault flag
//   and freezes the stage (bubbles, PC held, redirects ignored) until Reset.
//   Without the macro FetchFault is tied low and no range check exists.
//
// Handshake note: there is no valid/ready pair here. IF_ID_Valid qualifies
// the IF/ID contents each cycle; Stall is the only back-pressure and, while
// it is high, redirect inputs are not sampled (decode holds them).

module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegAddr,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus1,
    output logic        IF_ID_Valid,
    output logic        FetchFault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK_EN = 1'b1;
`else
    localparam bit BOUNDS_CHECK_EN = 1'b0;
`endif

    localparam logic [31:0] IMEM_DEPTH_W = 32'(IMEM_DEPTH);

    // Architectural state
    logic [31:0] pc_q,          pc_d;
    logic [31:0] ifid_instr_q,  ifid_instr_d;
    logic [31:0] ifid_pcp1_q,   ifid_pcp1_d;
    logic        ifid_valid_q,  ifid_valid_d;
    logic        fault_q,       fault_d;

    // Derived values
    logic [31:0] pc_plus1;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        out_of_range;

    // PC arithmetic and redirect target selection (JumpReg > Jump > Branch)
    always_comb begin
        pc_plus1      = pc_q + 32'd1;
        branch_target = ifid_pcp1_q + {{16{BranchOffset[15]}}, BranchOffset};
        jump_target   = {ifid_pcp1_q[31:26], JumpTarget};
        redirect      = JumpReg | Jump | BranchTaken;
        if (JumpReg) begin
            redirect_target = JumpRegAddr;
        end else if (Jump) begin
            redirect_target = jump_target;
        end else begin
            redirect_target = branch_target;
        end
        // Constant-false when the bounds check is compiled out
        out_of_range = BOUNDS_CHECK_EN && (pc_q >= IMEM_DEPTH_W);
    end

    // Next-state selection: fault freeze, stall, redirect, range check, sequential
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pcp1_d  = ifid_pcp1_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;

        if (fault_q) begin
            // Frozen after an out-of-range fetch: only Reset leaves this
            ifid_instr_d = 32'd0;
            ifid_pcp1_d  = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (Stall) begin
            // PC holds; Flush may still kill the held IF/ID contents
            if (Flush) begin
                ifid_instr_d = 32'd0;
                ifid_pcp1_d  = 32'd0;
                ifid_valid_d = 1'b0;
            end
        end else if (redirect) begin
            // Word fetched this cycle is on the wrong path: no delay slot
            pc_d         = redirect_target;
            ifid_instr_d = 32'd0;
            ifid_pcp1_d  = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (out_of_range) begin
            fault_d      = 1'b1;
            ifid_instr_d = 32'd0;
            ifid_pcp1_d  = 32'd0;
            ifid_valid_d = 1'b0;
        end else begin
            pc_d = pc_plus1;
            if (Flush) begin
                ifid_instr_d = 32'd0;
                ifid_pcp1_d  = 32'd0;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = Instruction;
                ifid_pcp1_d  = pc_plus1;
                ifid_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset overriding everything
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pcp1_q  <= 32'd0;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pcp1_q  <= ifid_pcp1_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign Address           = pc_q;
    assign IF_ID_Instruction = ifid_instr_q;
    assign IF_ID_PCPlus1     = ifid_pcp1_q;
    assign IF_ID_Valid       = ifid_valid_q;
    assign FetchFault        = BOUNDS_CHECK_EN ? fault_q : 1'b0;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch -- randomized + directed bench for instruction_fetch.
// Driver issues one cycle of inputs at each falling edge and pushes the
// reference model's post-edge outputs; the monitor pops one entry after
// every rising edge and compares.

module tb_instruction_fetch;

    localparam int unsigned DEPTH    = 16;
    localparam logic [31:0] RST_PC   = 32'd0;
    localparam int          MEM_WORDS = 128;
    localparam int          EXP_W    = 98;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'd0;
    logic        jump_reg = 1'b0;
    logic [31:0] jump_reg_addr = 32'd0;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcp1;
    logic        ifid_valid;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC   (RST_PC),
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .Clk               (clk),
        .Reset             (reset),
        .Stall             (stall),
        .Flush             (flush),
        .BranchTaken       (branch_taken),
        .BranchOffset      (branch_offset),
        .Jump              (jump),
        .JumpTarget        (jump_target),
        .JumpReg           (jump_reg),
        .JumpRegAddr       (jump_reg_addr),
        .Address           (address),
        .Instruction       (instruction),
        .IF_ID_Instruction (ifid_instr),
        .IF_ID_PCPlus1     (ifid_pcp1),
        .IF_ID_Valid       (ifid_valid),
        .FetchFault        (fetch_fault)
    );

    // ---------------- instruction memory ----------------
    logic [31:0] imem [MEM_WORDS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'(MEM_WORDS)) return imem[a[6:0]];
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always_comb begin
        if (address < 32'(MEM_WORDS)) instruction = imem[address[6:0]];
        else                          instruction = address ^ 32'hDEAD_BEEF;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pcp1  = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;

    function automatic void m_bubble();
        m_instr = 32'd0;
        m_pcp1  = 32'd0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_step(input logic rst, st, fl, br, input logic [15:0] off,
                                       input logic jp, input logic [25:0] jt,
                                       input logic jr, input logic [31:0] jra);
        logic [31:0] fetched_pc;
        if (rst) begin
            m_pc = RST_PC; m_fault = 1'b0; m_bubble();
        end else if (m_fault) begin
            m_bubble();
        end else if (st) begin
            if (fl) m_bubble();
        end else if (jr) begin
            m_pc = jra; m_bubble();
        end else if (jp) begin
            m_pc = {m_pcp1[31:26], jt}; m_bubble();
        end else if (br) begin
            m_pc = m_pcp1 + 32'($signed(off)); m_bubble();
        end else if (CHK && (m_pc >= 32'(DEPTH))) begin
            m_fault = 1'b1; m_bubble();
        end else begin
            fetched_pc = m_pc;
            m_pc = fetched_pc + 32'd1;
            if (fl) m_bubble();
            else begin
                m_instr = mem_word(fetched_pc);
                m_pcp1  = fetched_pc + 32'd1;
                m_valid = 1'b1;
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Monitor: one expected entry per rising edge
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("address",    address,             e[97:66]);
                check32("ifid_instr", ifid_instr,          e[65:34]);
                check32("ifid_pcp1",  ifid_pcp1,           e[33:2]);
                check32("ifid_valid", {31'd0, ifid_valid}, {31'd0, e[1]});
                check32("fetch_fault",{31'd0, fetch_fault},{31'd0, e[0]});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic rst, st, fl, br, input logic [15:0] off,
                         input logic jp, input logic [25:0] jt,
                         input logic jr, input logic [31:0] jra);
        @(negedge clk);
        reset = rst; stall = st; flush = fl;
        branch_taken = br; branch_offset = off;
        jump = jp; jump_target = jt;
        jump_reg = jr; jump_reg_addr = jra;
        model_step(rst, st, fl, br, off, jp, jt, jr, jra);
        exp_q.push_back({m_pc, m_instr, m_pcp1, m_valid, m_fault});
    endtask

    task automatic seq();              cycle(0,0,0,0,16'd0,0,26'd0,0,32'd0); endtask
    task automatic do_reset();         cycle(1,0,0,0,16'd0,0,26'd0,0,32'd0); endtask
    task automatic do_stall(input logic fl); cycle(0,1,fl,0,16'd0,0,26'd0,0,32'd0); endtask
    task automatic do_flush();         cycle(0,0,1,0,16'd0,0,26'd0,0,32'd0); endtask
    task automatic do_jr(input logic [31:0] a); cycle(0,0,0,0,16'd0,0,26'd0,1,a); endtask
    task automatic do_br(input logic [15:0] o); cycle(0,0,0,1,o,0,26'd0,0,32'd0); endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) imem[i] = $urandom();
        imem[0] = 32'h0062_2020;
        imem[1] = 32'h0145_4822;

        // Reset then release: IMEM[0], IMEM[1] captured in order
        do_reset();
        do_reset();
        seq();
        seq();

        // Stall three cycles at PC=5, then release
        do_jr(32'd5);
        do_stall(1'b0); do_stall(1'b0); do_stall(1'b0);
        seq();

        // Backward branch from IF_ID_PCPlus1=4 with offset -2
        do_jr(32'd3);
        seq();
        do_br(16'hFFFE);
        seq();
        seq();

        // All three redirects at once: JumpReg wins
        cycle(0,0,0,1,16'h0005,1,26'd9,1,32'h20);
        seq();
        seq();

        // Flush alone at PC=7, then Flush with Stall at PC=7
        do_jr(32'd7);
        do_flush();
        do_jr(32'd7);
        seq();
        do_jr(32'd7);
        do_stall(1'b1);
        seq();

        // Redirect to the first out-of-range word; redirects then ignored
        do_jr(32'd16);
        seq();
        seq();
        do_jr(32'd2);
        do_br(16'h0003);
        do_reset();
        seq();

        // PC wraparound
        do_jr(32'hFFFF_FFFF);
        seq();
        do_reset();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            logic rst, st, fl, br, jp, jr;
            rst = ($urandom_range(0, 99) < 3);
            st  = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 10);
            br  = ($urandom_range(0, 99) < 8);
            jp  = ($urandom_range(0, 99) < 6);
            jr  = ($urandom_range(0, 99) < 6);
            cycle(rst, st, fl, br, 16'($signed($urandom_range(0, 16)) - 8),
                  jp, 26'($urandom_range(0, 40)), jr, 32'($urandom_range(0, 40)));
        end

        // Drain with a bounded wait
        @(negedge clk);
        reset = 1'b0; stall = 1'b1;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
